// File: rtl/mch_enc_framer.sv
// mch_enc_framer: Manchester serialiser for head sync / length / payload / trailing sync frames.
// Optional macro MCH_TX_CRC_EN inserts a CRC-8 (poly 0x07) byte before the trailing sync.
module mch_enc_framer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_PL  = 16,
  parameter int unsigned MCH_POL = 0,
  localparam int unsigned SEL_W  = $clog2(MAX_PL + 3)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pls_1m,
  input  logic             sync_done,
  input  logic [DW-1:0]    p_data,
  output logic [SEL_W-1:0] d_sel,
  output logic             txsdo,
  output logic             busy,
  output logic             p2s_end
);

  localparam int unsigned SH_W = (DW > 8) ? DW : 8;
  localparam int unsigned BC_W = $clog2(SH_W);
  localparam int unsigned PC_W = $clog2(MAX_PL + 1);
  localparam logic [SEL_W-1:0] SEL_TAIL  = SEL_W'(MAX_PL + 2);
  localparam logic [BC_W-1:0]  BITS_DW   = BC_W'(DW - 1);
  localparam logic [PC_W-1:0]  PL_MAX    = PC_W'(MAX_PL);
  // IEEE coding: first half-bit is the complement of the data bit.
  localparam logic             INV_FIRST = (MCH_POL == 0);

  typedef enum logic [2:0] {
    StIdle,
    StHead,
    StLen,
    StPay,
`ifdef MCH_TX_CRC_EN
    StCrc,
`endif
    StTail
  } state_e;

`ifdef MCH_TX_CRC_EN
  localparam state_e ST_AFTER = StCrc;
`else
  localparam state_e ST_AFTER = StTail;
`endif

  state_e           r_state, w_state;
  logic [SH_W-1:0]  r_sh, w_sh, w_load_val;
  logic [BC_W-1:0]  r_bits, w_bits;
  logic             r_half, w_half;
  logic             r_load, w_load;
  logic             r_fin, w_fin;
  logic [PC_W-1:0]  r_pay_left, w_pay_left, w_len_n;
  logic [SEL_W-1:0] r_d_sel, w_d_sel;
  logic             r_tx, w_tx;
  logic             r_busy, w_busy;
  logic             r_end, w_end;
  logic             w_bit;

`ifdef MCH_TX_CRC_EN
  logic [7:0] r_crc, w_crc;

  function automatic logic [7:0] crc_next(input logic [7:0] crc, input logic din);
    crc_next = {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? 8'h07 : 8'h00);
  endfunction
`endif

  assign w_len_n = (32'(p_data) > MAX_PL) ? PL_MAX : PC_W'(p_data);

  // Bytes are left-aligned so the MSB is always at the top of the shifter.
  always_comb begin
    w_load_val = SH_W'(p_data) << (SH_W - DW);
`ifdef MCH_TX_CRC_EN
    if (r_state == StCrc) w_load_val = SH_W'(r_crc) << (SH_W - 8);
`endif
  end

  always_comb begin
    w_state    = r_state;
    w_sh       = r_sh;
    w_bits     = r_bits;
    w_half     = r_half;
    w_load     = r_load;
    w_fin      = r_fin;
    w_pay_left = r_pay_left;
    w_d_sel    = r_d_sel;
    w_tx       = r_tx;
    w_busy     = r_busy;
    w_end      = 1'b0;
    w_bit      = 1'b0;
`ifdef MCH_TX_CRC_EN
    w_crc      = r_crc;
`endif
    if (r_state == StIdle) begin
      w_tx = 1'b0;
      // The p2s_end cycle is still part of the finished frame.
      if (sync_done && !r_end) begin
        w_state    = StHead;
        w_busy     = 1'b1;
        w_d_sel    = '0;
        w_load     = 1'b1;
        w_half     = 1'b0;
        w_fin      = 1'b0;
        w_pay_left = '0;
`ifdef MCH_TX_CRC_EN
        w_crc      = '0;
`endif
      end
    end else if (pls_1m) begin
      if (r_fin) begin
        w_state    = StIdle;
        w_tx       = 1'b0;
        w_end      = 1'b1;
        w_busy     = 1'b0;
        w_d_sel    = '0;
        w_fin      = 1'b0;
        w_sh       = '0;
        w_bits     = '0;
        w_half     = 1'b0;
        w_pay_left = '0;
      end else if (r_load) begin
        w_sh   = w_load_val;
        w_bit  = w_load_val[SH_W-1];
        w_tx   = w_bit ^ INV_FIRST;
        w_half = 1'b1;
        w_load = 1'b0;
        w_bits = BITS_DW;
`ifdef MCH_TX_CRC_EN
        if (r_state == StCrc) w_bits = BC_W'(7);
        if (r_state == StLen || r_state == StPay) w_crc = crc_next(r_crc, w_bit);
`endif
        case (r_state)
          StHead: w_d_sel = SEL_W'(1);
          StLen: begin
            w_pay_left = w_len_n;
            w_d_sel    = (w_len_n == '0) ? SEL_TAIL : SEL_W'(2);
          end
          StPay: begin
            w_pay_left = r_pay_left - PC_W'(1);
            w_d_sel    = (r_pay_left == PC_W'(1)) ? SEL_TAIL : r_d_sel + SEL_W'(1);
          end
          default: w_d_sel = SEL_TAIL;
        endcase
      end else if (r_half) begin
        w_tx   = ~r_tx;
        w_half = 1'b0;
        if (r_bits == '0) begin
          case (r_state)
            StHead: begin
              w_state = StLen;
              w_load  = 1'b1;
            end
            StLen, StPay: begin
              w_state = (r_pay_left != '0) ? StPay : ST_AFTER;
              w_load  = 1'b1;
            end
`ifdef MCH_TX_CRC_EN
            StCrc: begin
              w_state = StTail;
              w_load  = 1'b1;
            end
`endif
            default: w_fin = 1'b1;
          endcase
        end
      end else begin
        w_sh   = r_sh << 1;
        w_bit  = r_sh[SH_W-2];
        w_tx   = w_bit ^ INV_FIRST;
        w_half = 1'b1;
        w_bits = r_bits - BC_W'(1);
`ifdef MCH_TX_CRC_EN
        if (r_state == StLen || r_state == StPay) w_crc = crc_next(r_crc, w_bit);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_sh       <= '0;
      r_bits     <= '0;
      r_half     <= 1'b0;
      r_load     <= 1'b0;
      r_fin      <= 1'b0;
      r_pay_left <= '0;
      r_d_sel    <= '0;
      r_tx       <= 1'b0;
      r_busy     <= 1'b0;
      r_end      <= 1'b0;
`ifdef MCH_TX_CRC_EN
      r_crc      <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_sh       <= w_sh;
      r_bits     <= w_bits;
      r_half     <= w_half;
      r_load     <= w_load;
      r_fin      <= w_fin;
      r_pay_left <= w_pay_left;
      r_d_sel    <= w_d_sel;
      r_tx       <= w_tx;
      r_busy     <= w_busy;
      r_end      <= w_end;
`ifdef MCH_TX_CRC_EN
      r_crc      <= w_crc;
`endif
    end
  end

  assign d_sel   = r_d_sel;
  assign txsdo   = r_tx;
  assign busy    = r_busy;
  assign p2s_end = r_end;

endmodule

// File: tb/tb_mch_enc_framer.sv
// tb_mch_enc_framer: random and directed frames checked against a byte-level Manchester model.
module tb_mch_enc_framer;

  localparam int unsigned DW       = 8;
  localparam int unsigned MAX_PL   = 16;
  localparam int unsigned MCH_POL  = 0;
  localparam int unsigned SEL_W    = $clog2(MAX_PL + 3);
  localparam int          TAIL_SEL = MAX_PL + 2;
`ifdef MCH_TX_CRC_EN
  localparam int          CRC_BYTES = 1;
`else
  localparam int          CRC_BYTES = 0;
`endif

  logic             clk;
  logic             rst;
  logic             pls_1m;
  logic             sync_done;
  logic [DW-1:0]    p_data;
  logic [SEL_W-1:0] d_sel;
  logic             txsdo;
  logic             busy;
  logic             p2s_end;

  logic [DW-1:0] mem [0:MAX_PL+2];
  int  errors = 0;
  int  checks = 0;
  bit  got_q[$];
  bit  exp_q[$];
  int  dsel_q[$];
  int  exp_sel[$];
  int  exp_crc;
  int  exp_n;

  mch_enc_framer #(
    .DW     (DW),
    .MAX_PL (MAX_PL),
    .MCH_POL(MCH_POL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pls_1m   (pls_1m),
    .sync_done(sync_done),
    .p_data   (p_data),
    .d_sel    (d_sel),
    .txsdo    (txsdo),
    .busy     (busy),
    .p2s_end  (p2s_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External byte mux
  assign p_data = mem[d_sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit tick);
    pls_1m = tick;
    @(posedge clk);
    #1;
    pls_1m    = 1'b0;
    sync_done = 1'b0;
  endtask

  function automatic void push_byte(input int val, input int w);
    bit v;
    bit first;
    for (int b = w - 1; b >= 0; b--) begin
      v     = ((val >> b) & 1) != 0;
      first = (MCH_POL == 0) ? !v : v;
      exp_q.push_back(first);
      exp_q.push_back(!first);
    end
  endfunction

  function automatic int crc8(input int crc_in, input int val, input int w);
    int crc;
    int fb;
    crc = crc_in;
    for (int b = w - 1; b >= 0; b--) begin
      fb  = ((crc >> 7) ^ (val >> b)) & 1;
      crc = (crc << 1) & 'hFF;
      if (fb != 0) crc = crc ^ 'h07;
    end
    return crc;
  endfunction

  function automatic void build_expect();
    int crc;
    exp_q.delete();
    exp_sel.delete();
    exp_n = (int'(mem[1]) > MAX_PL) ? MAX_PL : int'(mem[1]);
    exp_sel.push_back(0);
    exp_sel.push_back(1);
    push_byte(int'(mem[0]), DW);
    push_byte(int'(mem[1]), DW);
    crc = crc8(0, int'(mem[1]), DW);
    for (int i = 0; i < exp_n; i++) begin
      exp_sel.push_back(2 + i);
      push_byte(int'(mem[2+i]), DW);
      crc = crc8(crc, int'(mem[2+i]), DW);
    end
    exp_sel.push_back(TAIL_SEL);
    exp_crc = crc;
    if (CRC_BYTES != 0) push_byte(crc, 8);
    push_byte(int'(mem[MAX_PL+2]), DW);
  endfunction

  // Recover data bits from the second half of each captured bit cell.
  function automatic int decode(input int start, input int w);
    int v;
    v = 0;
    for (int i = 0; i < w; i++) begin
      v = (v << 1) | (int'(got_q[start + 2 * i + 1]) ^ ((MCH_POL != 0) ? 1 : 0));
    end
    return v;
  endfunction

  task automatic run_frame(input string tag, input int gap_max, input bit poke);
    int gap, ends, bad_hold, bad, poke_at, idle_bad, nmin;
    bit t, prev_tx;
    build_expect();
    got_q.delete();
    dsel_q.delete();
    sync_done = 1'b1;
    step(1'b0);
    chk({tag, "/accept_busy"}, busy, 1);
    chk({tag, "/accept_dsel"}, d_sel, 0);
    dsel_q.push_back(int'(d_sel));
    gap      = $urandom_range(gap_max, 0);
    ends     = 0;
    bad_hold = 0;
    prev_tx  = txsdo;
    poke_at  = exp_q.size() / 3;
    for (int cyc = 0; cyc < 3000 && ends == 0; cyc++) begin
      t = (gap == 0);
      if (t) gap = $urandom_range(gap_max, 0);
      else gap--;
      if (poke && t && (got_q.size() == poke_at || got_q.size() == exp_q.size()))
        sync_done = 1'b1;
      step(t);
      if (p2s_end === 1'b1) ends++;
      else if (t) got_q.push_back(txsdo);
      else if (txsdo !== prev_tx) bad_hold++;
      if (busy === 1'b1 && int'(d_sel) != dsel_q[$]) dsel_q.push_back(int'(d_sel));
      prev_tx = txsdo;
    end
    chk({tag, "/p2s_end_seen"}, ends, 1);
    chk({tag, "/end_txsdo"}, txsdo, 0);
    chk({tag, "/end_busy"}, busy, 0);
    chk({tag, "/end_dsel"}, d_sel, 0);
    chk({tag, "/ticks"}, got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    bad  = 0;
    for (int i = 0; i < nmin; i++) if (got_q[i] != exp_q[i]) bad++;
    chk({tag, "/halfbit_errs"}, bad, 0);
    chk({tag, "/hold_errs"}, bad_hold, 0);
    chk({tag, "/dsel_count"}, dsel_q.size(), exp_sel.size());
    nmin = (dsel_q.size() < exp_sel.size()) ? dsel_q.size() : exp_sel.size();
    bad  = 0;
    for (int i = 0; i < nmin; i++) if (dsel_q[i] != exp_sel[i]) bad++;
    chk({tag, "/dsel_errs"}, bad, 0);
    // sync_done during the p2s_end cycle must be ignored
    sync_done = 1'b1;
    idle_bad  = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      if (busy !== 1'b0 || txsdo !== 1'b0 || p2s_end !== 1'b0) idle_bad++;
    end
    chk({tag, "/idle_after"}, idle_bad, 0);
  endtask

  initial begin
    logic [15:0] pat_a5;
    int bad;
    int reached;
    rst       = 1'b1;
    pls_1m    = 1'b0;
    sync_done = 1'b0;
    for (int i = 0; i <= MAX_PL + 2; i++) mem[i] = '0;
    step(1'b0);
    step(1'b1);
    chk("reset/txsdo", txsdo, 0);
    chk("reset/busy", busy, 0);
    chk("reset/p2s_end", p2s_end, 0);
    chk("reset/dsel", d_sel, 0);
    rst = 1'b0;
    step(1'b1);
    step(1'b1);
    chk("idle_tick/txsdo", txsdo, 0);
    chk("idle_tick/busy", busy, 0);

    // Length 0, 0xA5 syncs
    mem[0] = 8'hA5;
    mem[1] = 8'h00;
    mem[MAX_PL+2] = 8'hA5;
    run_frame("len0", 2, 1'b0);
    chk("len0/ticks_abs", got_q.size(), (CRC_BYTES != 0) ? 64 : 48);
    pat_a5 = 16'b0110_0110_1001_1001;
    bad = 0;
    for (int i = 0; i < 16; i++) if (got_q[i] != pat_a5[15-i]) bad++;
    chk("len0/head_pattern", bad, 0);
    chk("len0/len_byte", decode(16, 8), 8'h00);
    chk("len0/tail_byte", decode(32 + 16 * CRC_BYTES, 8), 8'hA5);
    if (CRC_BYTES != 0) chk("len0/crc", decode(32, 8), 8'h00);

    // Length 4, payload 01..04
    mem[1] = 8'h04;
    for (int i = 0; i < 4; i++) mem[2+i] = DW'(i + 1);
    run_frame("len4", 1, 1'b1);
    chk("len4/ticks_abs", got_q.size(), (CRC_BYTES != 0) ? 128 : 112);
    for (int i = 0; i < 4; i++) chk($sformatf("len4/pay%0d", i), decode(32 + 16 * i, 8), i + 1);

    // Length 1, payload 00
    mem[1] = 8'h01;
    mem[2] = 8'h00;
    run_frame("len1", 0, 1'b0);
    chk("len1/ticks_abs", got_q.size(), (CRC_BYTES != 0) ? 80 : 64);
    if (CRC_BYTES != 0) chk("len1/crc", decode(48, 8), 8'h15);

    // Length 0xFF clamps to MAX_PL
    mem[1] = 8'hFF;
    for (int i = 0; i < MAX_PL; i++) mem[2+i] = DW'($urandom);
    run_frame("lenFF", 1, 1'b1);
    chk("lenFF/ticks_abs", got_q.size(), 16 * (3 + 16 + CRC_BYTES));
    chk("lenFF/len_byte", decode(16, 8), 8'hFF);

    // Random frames
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i <= MAX_PL + 2; i++) mem[i] = DW'($urandom);
      mem[1] = DW'($urandom_range(20, 0));
      run_frame($sformatf("rand%0d", k), $urandom_range(3, 0), k[0]);
    end

    // Reset mid-payload
    mem[1] = 8'h04;
    build_expect();
    sync_done = 1'b1;
    step(1'b0);
    reached = 0;
    for (int cyc = 0; cyc < 500 && reached == 0; cyc++) begin
      step(1'b1);
      if (d_sel === SEL_W'(4)) reached = 1;
    end
    chk("rst_mid/reached_pay", reached, 1);
    step(1'b1);
    step(1'b1);
    rst       = 1'b1;
    sync_done = 1'b1;
    step(1'b1);
    rst = 1'b0;
    chk("rst_mid/txsdo", txsdo, 0);
    chk("rst_mid/busy", busy, 0);
    chk("rst_mid/p2s_end", p2s_end, 0);
    chk("rst_mid/dsel", d_sel, 0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1);
      if (p2s_end !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rst_mid/quiet", bad, 0);
    run_frame("after_rst", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
